// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, line levels,
// parity types and the supported oversampling ratios.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Any ratio other than 16 or 32 falls back to the slowest-safe 8x.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling timer: counts clocks within a bit, takes three
// samples around mid-bit and majority-votes them into sampled_bit.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic       rx_s,
  input  logic [5:0] prescale,
  output logic       sampled_bit,
  output logic       bit_end
);

  logic [5:0] edge_cnt;
  logic [5:0] half;
  logic [2:0] samples;

  assign half    = {1'b0, prescale[5:1]};
  assign bit_end = en && (edge_cnt == prescale - 6'd1);

  // The vote only reads flops, so it is settled from half+2 until the bit ends.
  assign sampled_bit = (samples[0] & samples[1]) |
                       (samples[0] & samples[2]) |
                       (samples[1] & samples[2]);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edge_cnt <= '0;
      samples  <= 3'b111;
    end else if (!en) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
      if (edge_cnt == half - 6'd1) samples[0] <= rx_s;
      if (edge_cnt == half)        samples[1] <= rx_s;
      if (edge_cnt == half + 6'd1) samples[2] <= rx_s;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises the line, frames start/data/parity/stop bits
// and reports each frame with a single-cycle valid or error pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             RX_IN,
  input  logic [5:0]       Prescale,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [WIDTH-1:0] P_DATA,
  output logic             Data_Valid,
  output logic             Par_Err,
  output logic             Stop_Err
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  rx_state_e        state, next_state;
  logic [1:0]       sync_q;
  logic             rx_s;
  logic             start_det;
  logic             sampled_bit;
  logic             bit_end;
  logic [5:0]       presc_q;
  logic             par_en_q;
  logic             par_typ_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;
  logic [WIDTH-1:0] shift_q;
  logic             par_fail;
  logic             stop_bad;
  logic             par_bad;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], RX_IN};
  end
  assign rx_s = sync_q[1];

  uart_rx_sampler u_sampler (
    .clk        (clk),
    .rstn       (rstn),
    .en         ((state != IDLE) || start_det),
    .rx_s       (rx_s),
    .prescale   (presc_q),
    .sampled_bit(sampled_bit),
    .bit_end    (bit_end)
  );

  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
  assign stop_bad = (sampled_bit != STOP_BIT);
  assign par_bad  = par_en_q && par_fail;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    start_det  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_s == START_BIT) begin
          start_det  = 1'b1;
          next_state = START;
        end
      end
      START: begin
        if (bit_end) next_state = (sampled_bit == START_BIT) ? DATA : IDLE;
      end
      DATA: begin
        if (bit_end && last_bit) next_state = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) next_state = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (rx_s == START_BIT) begin
            start_det  = 1'b1;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the shift register is reset with everything else; it is a handful
  // of flops, and a defined value keeps the parity reduction X-free.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q    <= PRESCALE_8;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_fail   <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stop_Err   <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stop_Err   <= 1'b0;

      if (start_det) begin
        presc_q   <= legal_prescale(Prescale);
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        bit_cnt   <= '0;
        par_fail  <= 1'b0;
      end

      if (state == DATA && bit_end) begin
        shift_q[bit_cnt] <= sampled_bit;
        bit_cnt          <= last_bit ? '0 : bit_cnt + 1'b1;
      end

      if (state == PARITY && bit_end)
        par_fail <= (sampled_bit != (par_typ_q ^ (^shift_q)));

      // Frame verdict; a bad frame leaves the last good word on P_DATA.
      if (state == STOP && bit_end) begin
        Stop_Err   <= stop_bad;
        Par_Err    <= par_bad;
        Data_Valid <= !stop_bad && !par_bad;
        if (!stop_bad && !par_bad) P_DATA <= shift_q;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomised frames
// scored against a frame-level model of the receiver's verdict.
module tb_uart_rx;

  localparam int  WIDTH = 8;
  localparam time CLK_P = 10;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             RX_IN = 1'b1;
  logic [5:0]       Prescale = 6'd8;
  logic             PAR_EN = 1'b0;
  logic             PAR_TYP = 1'b0;
  logic [WIDTH-1:0] P_DATA;
  logic             Data_Valid;
  logic             Par_Err;
  logic             Stop_Err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
  } res_t;

  res_t       ev_q[$];
  time        ev_t[$];
  logic [7:0] last_good = 8'h00;

  always #(CLK_P / 2) clk = ~clk;

  uart_rx #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .RX_IN     (RX_IN),
    .Prescale  (Prescale),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .Par_Err   (Par_Err),
    .Stop_Err  (Stop_Err)
  );

  // Every cycle carrying any pulse is logged with its time.
  always @(negedge clk) begin
    if (rstn && (Data_Valid || Par_Err || Stop_Err)) begin
      ev_q.push_back(res_t'({Data_Valid, Par_Err, Stop_Err, P_DATA}));
      ev_t.push_back($time);
    end
  end

  // Frame-level expectation: parity counts ones, stop must be high.
  function automatic res_t model(input logic [7:0] d, input logic pe, input logic pt,
                                 input logic pbit, input logic sbit, input logic [7:0] prev);
    res_t r;
    logic want_pbit;
    want_pbit = logic'($countones(d) % 2) ^ pt;
    r.pe   = pe && (pbit != want_pbit);
    r.se   = (sbit == 1'b0);
    r.dv   = !r.pe && !r.se;
    r.data = r.dv ? d : prev;
    return r;
  endfunction

  function automatic logic good_parity(input logic [7:0] d, input logic pt);
    return logic'($countones(d) % 2) ^ pt;
  endfunction

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_events();
    ev_q.delete();
    ev_t.delete();
  endtask

  task automatic pop_event(output res_t r, output time t, output bit ok);
    ok = (ev_q.size() > 0);
    r  = '0;
    t  = 0;
    if (ok) begin
      r = ev_q.pop_front();
      t = ev_t.pop_front();
    end
  endtask

  // Drives one frame at p_line clocks per bit; abort_at >= 0 stops early.
  task automatic send_frame(input logic [7:0] d, input int p_line, input logic pe,
                            input logic pbit, input logic sbit, input bit scramble,
                            input int abort_at, output time t0);
    logic bits[$];
    int   n;
    n = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pbit);
    bits.push_back(sbit);
    t0 = $time;
    foreach (bits[b]) begin
      RX_IN = bits[b];
      for (int c = 0; c < p_line; c++) begin
        if (n == abort_at) return;
        @(negedge clk);
        n++;
        if (scramble && n == 4) begin
          Prescale = 6'($urandom);
          PAR_EN   = 1'($urandom);
          PAR_TYP  = 1'($urandom);
        end
      end
    end
    RX_IN = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({Data_Valid, Par_Err, Stop_Err, P_DATA} !== 11'h0) begin
      errors++;
      $display("FAIL reset_outputs: dv=%b pe=%b se=%b data=%h, want all 0",
               Data_Valid, Par_Err, Stop_Err, P_DATA);
    end
    rstn = 1'b1;
    idle(5);
  endtask

  task automatic test_basic();
    res_t exp, got;
    time  t0, t;
    bit   ok;
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clear_events();
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0);
    idle(30);
    exp = model(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, last_good);
    checks++;
    if (ev_q.size() != 1) begin
      errors++;
      $display("FAIL basic_pulse_count: got %0d pulses, want 1", ev_q.size());
    end
    pop_event(got, t, ok);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL basic_frame: got dv=%b pe=%b se=%b data=%h, want dv=%b pe=%b se=%b data=%h",
               got.dv, got.pe, got.se, got.data, exp.dv, exp.pe, exp.se, exp.data);
    end
    checks++;
    if (!ok || t - t0 < 81 * CLK_P || t - t0 > 83 * CLK_P) begin
      errors++;
      $display("FAIL basic_latency: got %0t after start, want 81..83 clocks", t - t0);
    end
    if (exp.dv) last_good = exp.data;
  endtask

  task automatic test_parity();
    res_t exp, got;
    time  t0, t;
    bit   ok;
    for (int k = 0; k < 2; k++) begin
      logic pbit;
      pbit = (k == 0) ? 1'b1 : 1'b0;
      Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
      clear_events();
      send_frame(8'h37, 16, 1'b1, pbit, 1'b1, 1'b0, -1, t0);
      idle(40);
      exp = model(8'h37, 1'b1, 1'b0, pbit, 1'b1, last_good);
      checks++;
      if (ev_q.size() != 1) begin
        errors++;
        $display("FAIL parity_pulse_count[%0d]: got %0d pulses, want 1", k, ev_q.size());
      end
      pop_event(got, t, ok);
      checks++;
      if (!ok || got !== exp) begin
        errors++;
        $display("FAIL parity_frame[%0d]: got dv=%b pe=%b se=%b data=%h, want dv=%b pe=%b se=%b data=%h",
                 k, got.dv, got.pe, got.se, got.data, exp.dv, exp.pe, exp.se, exp.data);
      end
      if (exp.dv) last_good = exp.data;
    end
    checks++;
    if (P_DATA !== 8'h37) begin
      errors++;
      $display("FAIL parity_data_held: P_DATA=%h, want 37", P_DATA);
    end
  endtask

  task automatic test_stop_err();
    res_t exp, got;
    time  t0, t;
    bit   ok;
    Prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    clear_events();
    send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b0, -1, t0);
    idle(80);
    exp = model(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, last_good);
    checks++;
    if (ev_q.size() != 1) begin
      errors++;
      $display("FAIL stop_pulse_count: got %0d pulses, want 1", ev_q.size());
    end
    pop_event(got, t, ok);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL stop_frame: got dv=%b pe=%b se=%b data=%h, want dv=%b pe=%b se=%b data=%h",
               got.dv, got.pe, got.se, got.data, exp.dv, exp.pe, exp.se, exp.data);
    end
  endtask

  task automatic test_glitch();
    res_t exp, got;
    time  t0, t;
    bit   ok;
    Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clear_events();
    RX_IN = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    checks++;
    if (ev_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_no_pulse: got %0d pulses, want 0", ev_q.size());
    end
    clear_events();
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0);
    idle(40);
    exp = model(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, last_good);
    pop_event(got, t, ok);
    checks++;
    if (!ok || got !== exp || ev_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_next_frame: got dv=%b pe=%b se=%b data=%h extra=%0d, want dv=%b pe=%b se=%b data=%h",
               got.dv, got.pe, got.se, got.data, ev_q.size(), exp.dv, exp.pe, exp.se, exp.data);
    end
    if (exp.dv) last_good = exp.data;
  endtask

  task automatic test_back_to_back();
    time t0a, t0b;
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clear_events();
    send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0a);
    send_frame(8'hFE, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0b);
    idle(30);
    checks++;
    if (ev_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_pulse_count: got %0d pulses, want 2", ev_q.size());
    end else begin
      checks++;
      if (ev_q[0] !== res_t'({3'b100, 8'h01}) || ev_q[1] !== res_t'({3'b100, 8'hFE})) begin
        errors++;
        $display("FAIL b2b_data: got %h then %h, want valid 01 then valid FE",
                 ev_q[0].data, ev_q[1].data);
      end
      checks++;
      if (ev_t[1] - ev_t[0] != 80 * CLK_P) begin
        errors++;
        $display("FAIL b2b_spacing: got %0t, want %0t", ev_t[1] - ev_t[0], 80 * CLK_P);
      end
      last_good = 8'hFE;
    end
  endtask

  task automatic test_reset_mid_frame();
    res_t exp, got;
    time  t0, t;
    bit   ok;
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clear_events();
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 44, t0);
    rstn = 1'b0;
    #1;
    checks++;
    if ({Data_Valid, Par_Err, Stop_Err, P_DATA} !== 11'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: dv=%b pe=%b se=%b data=%h, want all 0",
               Data_Valid, Par_Err, Stop_Err, P_DATA);
    end
    RX_IN = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    last_good = 8'h00;
    idle(40);
    checks++;
    if (ev_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_no_pulse: got %0d pulses, want 0", ev_q.size());
    end
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0);
    idle(30);
    exp = model(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, last_good);
    pop_event(got, t, ok);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL reset_mid_next_frame: got dv=%b data=%h, want dv=%b data=%h",
               got.dv, got.data, exp.dv, exp.data);
    end
    if (exp.dv) last_good = exp.data;
  endtask

  // Random data, ratio, parity mode and line faults; config inputs are
  // scrambled mid-frame and must not disturb the frame in flight.
  task automatic test_random();
    res_t exp, got;
    time  t0, t;
    bit   ok;
    for (int it = 0; it < 20; it++) begin
      int         sel, p_line;
      logic [5:0] cfg;
      logic [7:0] d;
      logic       pe, pt, pbit, sbit;
      sel    = $urandom_range(0, 3);
      p_line = (sel == 1) ? 16 : (sel == 2) ? 32 : 8;
      cfg    = 6'(p_line);
      if (sel == 3) begin
        do cfg = 6'($urandom); while (cfg inside {6'd8, 6'd16, 6'd32});
      end
      d    = 8'($urandom);
      pe   = 1'($urandom);
      pt   = 1'($urandom);
      pbit = good_parity(d, pt) ^ ($urandom_range(0, 3) == 0);
      sbit = ($urandom_range(0, 3) != 0);
      Prescale = cfg; PAR_EN = pe; PAR_TYP = pt;
      clear_events();
      send_frame(d, p_line, pe, pbit, sbit, 1'b1, -1, t0);
      idle(80);
      exp = model(d, pe, pt, pbit, sbit, last_good);
      checks++;
      if (ev_q.size() != 1) begin
        errors++;
        $display("FAIL rand_pulse_count[%0d]: got %0d pulses, want 1", it, ev_q.size());
      end
      pop_event(got, t, ok);
      checks++;
      if (!ok || got !== exp) begin
        errors++;
        $display("FAIL rand_frame[%0d] p=%0d cfg=%0d pe=%b pt=%b: got dv=%b pe=%b se=%b data=%h, want dv=%b pe=%b se=%b data=%h",
                 it, p_line, cfg, pe, pt, got.dv, got.pe, got.se, got.data,
                 exp.dv, exp.pe, exp.se, exp.data);
      end
      if (exp.dv) last_good = exp.data;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
